// File: rtl/nor_array_pkg.sv
// Shared constants and helpers for the parametrised NOR gate array.
// Delay modes and the inertial counter width calculation.
package nor_array_pkg;

    localparam int MODE_TRANSPORT = 0;
    localparam int MODE_INERTIAL  = 1;

    function automatic int cnt_width(input int delay);
        return $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/nor_delay_channel.sv
// One NOR gate with a clocked propagation delay.
// Transport mode uses a shift register; inertial mode uses a persistence counter.
module nor_delay_channel
    import nor_array_pkg::*;
#(
    parameter int   FANIN    = 4,
    parameter int   DELAY    = 1,
    parameter logic IC       = 1'b0,
    parameter int   INERTIAL = MODE_TRANSPORT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [FANIN-1:0] a_i,
    output logic             y_o
);

    logic target_s;

    assign target_s = ~|a_i;

    if (INERTIAL == MODE_INERTIAL) begin : g_inertial
        localparam int            CW      = cnt_width(DELAY);
        localparam logic [CW-1:0] CNT_MAX = CW'(DELAY - 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          y_q, y_d;

        // Output only follows the target after it has persisted for DELAY edges.
        always_comb begin
            y_d   = y_q;
            cnt_d = cnt_q;
            if (target_s == y_q) begin
                cnt_d = {CW{1'b0}};
            end else if (cnt_q == CNT_MAX) begin
                y_d   = target_s;
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end

        // Counter and output state; reset and power loss both reload the initial value.
        always_ff @(posedge clk_i) begin
            if (rst_i || load_i) begin
                y_q   <= IC;
                cnt_q <= {CW{1'b0}};
            end else begin
                y_q   <= y_d;
                cnt_q <= cnt_d;
            end
        end

        assign y_o = y_q;
    end else begin : g_transport
        logic [DELAY-1:0] s_q, s_d;

        if (DELAY == 1) begin : g_single
            assign s_d = target_s;
        end else begin : g_multi
            assign s_d = {s_q[DELAY-2:0], target_s};
        end

        // Delay line; every pulse reappears DELAY-1 edges after it is first sampled.
        always_ff @(posedge clk_i) begin
            if (rst_i || load_i) begin
                s_q <= {DELAY{IC}};
            end else begin
                s_q <= s_d;
            end
        end

        assign y_o = s_q[DELAY-1];
    end

endmodule

// File: rtl/nor_gate_array.sv
// N-channel, M-input NOR gate array with clocked propagation delay.
// Outputs are forced low whenever the supply pins are not in their powered state.
module nor_gate_array
    import nor_array_pkg::*;
#(
    parameter int          CHANNELS = 2,
    parameter int          FANIN    = 4,
    parameter int          DELAY    = 1,
    parameter logic [63:0] IC       = 64'd0,
    parameter int          INERTIAL = MODE_TRANSPORT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vcc,
    input  logic                      gnd,
    input  logic [CHANNELS*FANIN-1:0] a,
    output logic [CHANNELS-1:0]       y
);

    if (CHANNELS < 1 || CHANNELS > 64) begin : g_err_channels
        $error("nor_gate_array: CHANNELS must be in 1..64");
    end
    if (FANIN < 1) begin : g_err_fanin
        $error("nor_gate_array: FANIN must be >= 1");
    end
    if (DELAY < 1) begin : g_err_delay
        $error("nor_gate_array: DELAY must be >= 1");
    end
    if (CHANNELS < 64 && (IC >> CHANNELS) != 64'd0) begin : g_err_ic
        $error("nor_gate_array: IC has bits set above CHANNELS");
    end

    logic                powered_s;
    logic [CHANNELS-1:0] ch_y_s;

    assign powered_s = vcc & ~gnd;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        nor_delay_channel #(
            .FANIN    (FANIN),
            .DELAY    (DELAY),
            .IC       (IC[i]),
            .INERTIAL (INERTIAL)
        ) u_ch (
            .clk_i  (clk),
            .rst_i  (rst),
            .load_i (~powered_s),
            .a_i    (a[i*FANIN +: FANIN]),
            .y_o    (ch_y_s[i])
        );
    end

    assign y = powered_s ? ch_y_s : {CHANNELS{1'b0}};

endmodule
